assoc_wb_cache: RTL and testbench

- Parametrised N-way set-associative, write-back, write-allocate data cache with true-LRU replacement.
- Sits between the core's load/store unit and main data memory.
- One-word lines; byte-enable writes.
- Explicit req/ready handshake on the CPU side and req/ack handshake on the memory side, so memory latency is arbitrary.

---
 rtl/assoc_wb_cache.sv | 239 +++++++++++++++++++++++
 tb/tb_assoc_wb_cache.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/assoc_wb_cache.sv
// N-way set-associative write-back/write-allocate data cache with true-LRU replacement.
// Defining CACHE_FLUSH_EN adds i_flush/o_flush_done and a walk that writes back every dirty line.
module assoc_wb_cache #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SETS   = 8,
  parameter int unsigned WAYS   = 2
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_cpu_req,
  input  logic                i_cpu_we,
  input  logic [DATA_W/8-1:0] i_cpu_be,
  input  logic [ADDR_W-1:0]   i_cpu_addr,
  input  logic [DATA_W-1:0]   i_cpu_wdata,
  output logic [DATA_W-1:0]   o_cpu_rdata,
  output logic                o_cpu_ready,
`ifdef CACHE_FLUSH_EN
  input  logic                i_flush,
  output logic                o_flush_done,
`endif
  output logic                o_mem_req,
  output logic                o_mem_we,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  input  logic [DATA_W-1:0]   i_mem_rdata,
  input  logic                i_mem_ack
);
  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(BE_W);
  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = ADDR_W - OFF_W - IDX_W;
  localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {
    StIdle, StWriteback, StRefill, StResp
`ifdef CACHE_FLUSH_EN
    , StFlush, StFlushDone
`endif
  } state_e;

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                              input logic [DATA_W-1:0] new_w,
                                              input logic [BE_W-1:0]   be);
    merge = old_w;
    for (int b = 0; b < BE_W; b++) if (be[b]) merge[8*b +: 8] = new_w[8*b +: 8];
  endfunction

  state_e             r_state, w_state_d;
  logic               r_valid [SETS][WAYS];
  logic               r_dirty [SETS][WAYS];
  logic [TAG_W-1:0]   r_tag   [SETS][WAYS];
  logic [DATA_W-1:0]  r_data  [SETS][WAYS];
  logic [WAY_W-1:0]   r_victim;
  logic [DATA_W-1:0]  r_rdata;
  logic               r_gap;

  logic [IDX_W-1:0]   w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic [WAYS-1:0]    w_hit_vec;
  logic               w_hit, w_take, w_hit_fire, w_miss, w_fill, w_mem_req, w_mem_ack;
  logic [WAY_W-1:0]   w_hit_way, w_victim, w_lru_way;
  logic [DATA_W-1:0]  w_hit_data, w_fill_data;

  assign w_tag = i_cpu_addr[ADDR_W-1 -: TAG_W];

`ifdef CACHE_FLUSH_EN
  logic             r_flushing;
  logic [IDX_W-1:0] r_fset;
  logic [WAY_W-1:0] r_fway;
  logic             w_fl_last, w_fl_dirty, w_fl_adv;
  assign w_idx      = r_flushing ? r_fset : i_cpu_addr[OFF_W +: IDX_W];
  assign w_take     = (r_state == StIdle) && i_cpu_req && !i_flush;
  assign w_fl_last  = (r_fset == IDX_W'(SETS - 1)) && (r_fway == WAY_W'(WAYS - 1));
  assign w_fl_dirty = r_valid[r_fset][r_fway] && r_dirty[r_fset][r_fway];
  assign w_fl_adv   = ((r_state == StFlush) && !w_fl_dirty) ||
                      ((r_state == StWriteback) && r_flushing && w_mem_ack);
  assign o_flush_done = (r_state == StFlushDone);
`else
  assign w_idx  = i_cpu_addr[OFF_W +: IDX_W];
  assign w_take = (r_state == StIdle) && i_cpu_req;
`endif

  for (genvar w = 0; w < WAYS; w++) begin : g_cmp
    assign w_hit_vec[w] = r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag);
  end

  always_comb begin
    w_hit_way = '0;
    w_victim  = w_lru_way;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (w_hit_vec[w]) w_hit_way = WAY_W'(w);
      if (!r_valid[w_idx][w]) w_victim = WAY_W'(w);
    end
  end

  assign w_hit       = |w_hit_vec;
  assign w_hit_fire  = w_take && w_hit;
  assign w_miss      = w_take && !w_hit;
  // r_gap forces one idle memory cycle after every ack (writeback -> refill included).
  assign w_mem_req   = ((r_state == StWriteback) || (r_state == StRefill)) && !r_gap;
  assign w_mem_ack   = w_mem_req && i_mem_ack;
  assign w_fill      = (r_state == StRefill) && w_mem_ack;
  assign w_hit_data  = r_data[w_idx][w_hit_way];
  assign w_fill_data = merge(i_mem_rdata, i_cpu_wdata, i_cpu_we ? i_cpu_be : '0);

  assign o_cpu_ready = (r_state == StResp);
  assign o_cpu_rdata = r_rdata;
  assign o_mem_req   = w_mem_req;

  always_comb begin
    w_state_d   = r_state;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    case (r_state)
      StIdle: begin
`ifdef CACHE_FLUSH_EN
        if (i_flush) w_state_d = StFlush;
        else
`endif
        if (i_cpu_req) begin
          if (w_hit) w_state_d = StResp;
          else if (r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim]) w_state_d = StWriteback;
          else w_state_d = StRefill;
        end
      end
      StWriteback: begin
        o_mem_we    = 1'b1;
        o_mem_addr  = ADDR_W'({r_tag[w_idx][r_victim], w_idx}) << OFF_W;
        o_mem_wdata = r_data[w_idx][r_victim];
        if (w_mem_ack) begin
`ifdef CACHE_FLUSH_EN
          if (r_flushing) w_state_d = w_fl_last ? StFlushDone : StFlush;
          else
`endif
          w_state_d = StRefill;
        end
      end
      StRefill: begin
        o_mem_addr = (i_cpu_addr >> OFF_W) << OFF_W;
        if (w_mem_ack) w_state_d = StResp;
      end
      StResp: w_state_d = StIdle;
`ifdef CACHE_FLUSH_EN
      StFlush: begin
        if (w_fl_dirty) w_state_d = StWriteback;
        else if (w_fl_last) w_state_d = StFlushDone;
      end
      StFlushDone: w_state_d = StIdle;
`endif
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= StIdle;
      r_valid  <= '{default: '0};
      r_dirty  <= '{default: '0};
      r_victim <= '0;
      r_rdata  <= '0;
      r_gap    <= 1'b0;
`ifdef CACHE_FLUSH_EN
      r_flushing <= 1'b0;
      r_fset     <= '0;
      r_fway     <= '0;
`endif
    end else begin
      r_state <= w_state_d;
      r_gap   <= w_mem_ack;
      if (w_hit_fire) begin
        if (i_cpu_we) r_dirty[w_idx][w_hit_way] <= 1'b1;
        else          r_rdata <= w_hit_data;
      end
      if (w_miss) r_victim <= w_victim;
      if (w_fill) begin
        r_valid[w_idx][r_victim] <= 1'b1;
        r_dirty[w_idx][r_victim] <= i_cpu_we;
        r_rdata                  <= w_fill_data;
      end
`ifdef CACHE_FLUSH_EN
      if ((r_state == StIdle) && i_flush) begin
        r_flushing <= 1'b1;
        r_fset     <= '0;
        r_fway     <= '0;
      end
      if ((r_state == StFlush) && w_fl_dirty) r_victim <= r_fway;
      if ((r_state == StWriteback) && r_flushing && w_mem_ack) r_dirty[r_fset][r_victim] <= 1'b0;
      if (w_fl_adv) begin
        if (r_fway == WAY_W'(WAYS - 1)) begin
          r_fway <= '0;
          r_fset <= r_fset + 1'b1;
        end else begin
          r_fway <= r_fway + 1'b1;
        end
      end
      if (r_state == StFlushDone) r_flushing <= 1'b0;
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_hit_fire && i_cpu_we) r_data[w_idx][w_hit_way] <= merge(w_hit_data, i_cpu_wdata, i_cpu_be);
    if (w_fill) begin
      r_data[w_idx][r_victim] <= w_fill_data;
      r_tag[w_idx][r_victim]  <= w_tag;
    end
  end

  if (WAYS > 1) begin : g_lru
    logic [WAY_W-1:0] r_age [SETS][WAYS];
    logic [WAY_W-1:0] w_acc_way, w_acc_age;

    assign w_acc_way = w_hit_fire ? w_hit_way : r_victim;
    assign w_acc_age = r_age[w_idx][w_acc_way];

    always_comb begin
      w_lru_way = '0;
      for (int w = 0; w < WAYS; w++) if (r_age[w_idx][w] == WAY_W'(WAYS - 1)) w_lru_way = WAY_W'(w);
    end

    // Accessed way becomes youngest; only ways younger than it age by one.
    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
        for (int s = 0; s < SETS; s++)
          for (int w = 0; w < WAYS; w++) r_age[s][w] <= WAY_W'(w);
      end else if (w_hit_fire || w_fill) begin
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == w_acc_way) r_age[w_idx][w] <= '0;
          else if (r_age[w_idx][w] < w_acc_age) r_age[w_idx][w] <= r_age[w_idx][w] + 1'b1;
        end
      end
    end
  end else begin : g_no_lru
    assign w_lru_way = '0;
  end

endmodule

// File: tb/tb_assoc_wb_cache.sv
// Scoreboard bench for assoc_wb_cache: directed CPU ops, a scripted memory responder
// checking each memory transaction, and a response monitor popping expected load data.
module tb_assoc_wb_cache;
  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [3:0]  cpu_be;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_ready;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef CACHE_FLUSH_EN
  logic        flush, flush_done;
`endif

  assoc_wb_cache #(.ADDR_W(32), .DATA_W(32), .SETS(8), .WAYS(2)) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_cpu_req   (cpu_req),
    .i_cpu_we    (cpu_we),
    .i_cpu_be    (cpu_be),
    .i_cpu_addr  (cpu_addr),
    .i_cpu_wdata (cpu_wdata),
    .o_cpu_rdata (cpu_rdata),
    .o_cpu_ready (cpu_ready),
`ifdef CACHE_FLUSH_EN
    .i_flush     (flush),
    .o_flush_done(flush_done),
`endif
    .o_mem_req   (mem_req),
    .o_mem_we    (mem_we),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .i_mem_rdata (mem_rdata),
    .i_mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        noack;
  } mem_t;
  typedef struct {
    logic        chk;
    logic [31:0] rdata;
  } rsp_t;

  mem_t mem_q[$];
  rsp_t rsp_q[$];
  int   total = 0, bad = 0, mem_cnt = 0, fd_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_mem(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input logic noack);
    mem_q.push_back('{we, addr, wdata, rdata, noack});
  endtask

  // Response monitor
  always @(negedge clk) begin
    rsp_t e;
    if (!reset && cpu_ready) begin
      if (rsp_q.size() == 0) check("unexpected_ready", rsp_q.size(), 1);
      else begin
        e = rsp_q.pop_front();
        if (e.chk) check("cpu_rdata", cpu_rdata, e.rdata);
      end
    end
  end

`ifdef CACHE_FLUSH_EN
  always @(negedge clk) if (!reset && flush_done) fd_cnt++;
`endif

  // Memory responder: ack 3 cycles after a request is first seen
  initial begin
    mem_t e;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!reset && mem_req) begin
        mem_cnt++;
        if (mem_q.size() == 0) begin
          check("unexpected_mem", mem_q.size(), 1);
          for (int i = 0; i < 100 && mem_req; i++) @(negedge clk);
        end else begin
          e = mem_q.pop_front();
          check("mem_we", mem_we, e.we);
          check("mem_addr", mem_addr, e.addr);
          if (e.we) check("mem_wdata", mem_wdata, e.wdata);
          if (e.noack) begin
            for (int i = 0; i < 100 && mem_req; i++) @(negedge clk);
          end else begin
            repeat (2) @(negedge clk);
            check("mem_addr_hold", mem_addr, e.addr);
            mem_rdata = e.rdata;
            mem_ack   = 1'b1;
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = '0;
            check("mem_req_gap", mem_req, 1'b0);
          end
        end
      end
    end
  end

  task automatic cpu_op(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wd, input logic chk_rd, input logic [31:0] exp,
                        output int lat);
    rsp_q.push_back('{chk_rd, exp});
    @(negedge clk);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_be    = be;
    cpu_addr  = addr;
    cpu_wdata = wd;
    lat = 1;
    do begin
      @(negedge clk);
      lat++;
    end while (!cpu_ready && lat < 300);
    if (!cpu_ready) check("cpu_timeout", cpu_ready, 1'b1);
    cpu_req = 1'b0;
  endtask

  int lat, n, fd;

  initial begin
    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_be = '0; cpu_addr = '0; cpu_wdata = '0;
`ifdef CACHE_FLUSH_EN
    flush = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_cpu_ready", cpu_ready, 1'b0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_cpu_rdata", cpu_rdata, 32'h0);
    reset = 1'b0;

    // Cold miss, then hit
    push_mem(1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 1'b0);
    cpu_op(1'b0, 4'h0, 32'h40, 32'h0, 1'b1, 32'hDEADBEEF, lat);
    check("cold_miss_lat", lat, 5);
    check("cold_mem_cnt", mem_cnt, 1);
    n = mem_cnt;
    cpu_op(1'b0, 4'h0, 32'h40, 32'h0, 1'b1, 32'hDEADBEEF, lat);
    check("hit_lat", lat, 2);
    check("hit_no_mem", mem_cnt, n);

    // Byte store hit, then readback
    cpu_op(1'b1, 4'b0011, 32'h40, 32'h00001234, 1'b0, 32'h0, lat);
    check("store_hit_lat", lat, 2);
    cpu_op(1'b0, 4'h0, 32'h40, 32'h0, 1'b1, 32'hDEAD1234, lat);
    check("store_no_mem", mem_cnt, n);

    // Fill 0x60 clean, then 0x80 evicts dirty 0x40
    push_mem(1'b0, 32'h60, 32'h0, 32'h60606060, 1'b0);
    cpu_op(1'b0, 4'h0, 32'h60, 32'h0, 1'b1, 32'h60606060, lat);
    push_mem(1'b1, 32'h40, 32'hDEAD1234, 32'h0, 1'b0);
    push_mem(1'b0, 32'h80, 32'h0, 32'h80808080, 1'b0);
    cpu_op(1'b0, 4'h0, 32'h80, 32'h0, 1'b1, 32'h80808080, lat);
    n = mem_cnt;
    cpu_op(1'b0, 4'h0, 32'h60, 32'h0, 1'b1, 32'h60606060, lat);
    check("lru_keep_hit", mem_cnt, n);

    // Write-allocate over clean victim 0x80
    push_mem(1'b0, 32'h100, 32'h0, 32'h11223344, 1'b0);
    cpu_op(1'b1, 4'b1000, 32'h100, 32'hAB000000, 1'b1, 32'hAB223344, lat);
    check("walloc_one_refill", mem_cnt, n + 1);
    cpu_op(1'b0, 4'h0, 32'h100, 32'h0, 1'b1, 32'hAB223344, lat);
    check("walloc_hit", mem_cnt, n + 1);

    // Evict clean 0x60, then evict 0x100 proving it was left dirty
    push_mem(1'b0, 32'h40, 32'h0, 32'hDEAD1234, 1'b0);
    cpu_op(1'b0, 4'h0, 32'h40, 32'h0, 1'b1, 32'hDEAD1234, lat);
    push_mem(1'b1, 32'h100, 32'hAB223344, 32'h0, 1'b0);
    push_mem(1'b0, 32'h60, 32'h0, 32'h60606060, 1'b0);
    cpu_op(1'b0, 4'h0, 32'h60, 32'h0, 1'b1, 32'h60606060, lat);

    // Reset mid-refill
    push_mem(1'b0, 32'h80, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h80;
    for (int i = 0; i < 50 && !mem_req; i++) @(negedge clk);
    check("pre_rst_req", mem_req, 1'b1);
    #1 reset = 1'b1;
    #1;
    check("midrst_mem_req", mem_req, 1'b0);
    check("midrst_cpu_ready", cpu_ready, 1'b0);
    cpu_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    n = mem_cnt;
    push_mem(1'b0, 32'h40, 32'h0, 32'h55555555, 1'b0);
    cpu_op(1'b0, 4'h0, 32'h40, 32'h0, 1'b1, 32'h55555555, lat);
    check("after_rst_miss", mem_cnt, n + 1);

`ifdef CACHE_FLUSH_EN
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    push_mem(1'b0, 32'h40, 32'h0, 32'h0, 1'b0);
    cpu_op(1'b1, 4'hF, 32'h40, 32'h11111111, 1'b1, 32'h11111111, lat);
    push_mem(1'b0, 32'h44, 32'h0, 32'h0, 1'b0);
    cpu_op(1'b1, 4'hF, 32'h44, 32'h22222222, 1'b1, 32'h22222222, lat);
    push_mem(1'b1, 32'h40, 32'h11111111, 32'h0, 1'b0);
    push_mem(1'b1, 32'h44, 32'h22222222, 32'h0, 1'b0);
    rsp_q.push_back('{1'b1, 32'h11111111});
    n  = mem_cnt;
    fd = fd_cnt;
    @(negedge clk);
    flush = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
    @(negedge clk);
    flush = 1'b0;
    for (int i = 0; i < 400 && !cpu_ready; i++) @(negedge clk);
    check("flush_ready", cpu_ready, 1'b1);
    cpu_req = 1'b0;
    check("flush_done_pulse", fd_cnt, fd + 1);
    check("flush_wb_count", mem_cnt, n + 2);
    cpu_op(1'b0, 4'h0, 32'h44, 32'h0, 1'b1, 32'h22222222, lat);
    check("post_flush_hit", mem_cnt, n + 2);
`endif

    repeat (3) @(negedge clk);
    check("mem_q_empty", mem_q.size(), 0);
    check("rsp_q_empty", rsp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
